// File: rtl/decode_unit.sv
// RV32I decode stage: field slicing, immediate generation, branch/JAL targets and the
// 32-entry integer register file (two async read ports, one sync write port).
module decode_unit #(
   parameter int unsigned CORE         = 0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDRESS_BITS = 32
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic [ADDRESS_BITS-1:0] pc_i,
   input  logic [31:0]             instruction_i,
   input  logic [1:0]              extend_sel_i,
   input  logic                    write_i,
   input  logic [4:0]              write_reg_i,
   input  logic [DATA_WIDTH-1:0]   write_data_i,
   input  logic                    scan_i,
   output logic [DATA_WIDTH-1:0]   rs1_data_o,
   output logic [DATA_WIDTH-1:0]   rs2_data_o,
   output logic [4:0]              rd_o,
   output logic [6:0]              opcode_o,
   output logic [6:0]              funct7_o,
   output logic [2:0]              funct3_o,
   output logic [DATA_WIDTH-1:0]   extend_imm_o,
   output logic [ADDRESS_BITS-1:0] branch_target_o,
   output logic [ADDRESS_BITS-1:0] JAL_target_o
);

   logic [DATA_WIDTH-1:0]   regs_q [32];
   logic [DATA_WIDTH-1:0]   regs_d [32];
   logic [DATA_WIDTH-1:0]   imm_i_fmt;
   logic [DATA_WIDTH-1:0]   imm_s_fmt;
   logic [DATA_WIDTH-1:0]   imm_u_fmt;
   logic [ADDRESS_BITS-1:0] imm_b;
   logic [ADDRESS_BITS-1:0] imm_j;

   // The scan print is a simulation-only debug aid; the synthesizable core ignores it.
   logic [31:0] unused_dbg;
   assign unused_dbg = CORE ^ 32'(scan_i);

   assign rd_o     = instruction_i[11:7];
   assign opcode_o = instruction_i[6:0];
   assign funct7_o = instruction_i[31:25];
   assign funct3_o = instruction_i[14:12];

   assign imm_i_fmt = DATA_WIDTH'($signed(instruction_i[31:20]));
   assign imm_s_fmt = DATA_WIDTH'($signed({instruction_i[31:25], instruction_i[11:7]}));
   assign imm_u_fmt = DATA_WIDTH'($signed({instruction_i[31:12], 12'b0}));

   always_comb begin
      extend_imm_o = imm_i_fmt;
      unique case (extend_sel_i)
         2'b00, 2'b11: extend_imm_o = imm_i_fmt;
         2'b01:        extend_imm_o = imm_s_fmt;
         2'b10:        extend_imm_o = imm_u_fmt;
      endcase
   end

   assign imm_b = ADDRESS_BITS'($signed({instruction_i[31], instruction_i[7],
                                         instruction_i[30:25], instruction_i[11:8], 1'b0}));
   assign imm_j = ADDRESS_BITS'($signed({instruction_i[31], instruction_i[19:12],
                                         instruction_i[20], instruction_i[30:21], 1'b0}));

   assign branch_target_o = pc_i + imm_b;
   assign JAL_target_o    = pc_i + imm_j;

   // Entry 0 is never written, so it reads as the reset value 0.
   always_comb begin
      regs_d = regs_q;
      if (write_i && (write_reg_i != 5'd0)) begin
         regs_d[write_reg_i] = write_data_i;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rs1_data_o = regs_q[instruction_i[19:15]];
   assign rs2_data_o = regs_q[instruction_i[24:20]];

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: expectations are pushed when a vector is driven and
// popped/compared once the combinational outputs have settled.
module tb_decode_unit;

   logic        clock;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instruction;
   logic [1:0]  extend_sel;
   logic        write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        scan;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd;
   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [31:0] extend_imm;
   logic [31:0] branch_target;
   logic [31:0] jal_target;

   decode_unit #(
      .CORE         (0),
      .DATA_WIDTH   (32),
      .ADDRESS_BITS (32)
   ) u_dut (
      .clock_i         (clock),
      .reset_i         (reset),
      .pc_i            (pc),
      .instruction_i   (instruction),
      .extend_sel_i    (extend_sel),
      .write_i         (write),
      .write_reg_i     (write_reg),
      .write_data_i    (write_data),
      .scan_i          (scan),
      .rs1_data_o      (rs1_data),
      .rs2_data_o      (rs2_data),
      .rd_o            (rd),
      .opcode_o        (opcode),
      .funct7_o        (funct7),
      .funct3_o        (funct3),
      .extend_imm_o    (extend_imm),
      .branch_target_o (branch_target),
      .JAL_target_o    (jal_target)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] opcode;
      logic [31:0] funct7;
      logic [31:0] funct3;
      logic [31:0] imm;
      logic [31:0] bt;
      logic [31:0] jt;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_rf [32];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference decode built from shifts and masks on the whole instruction word.
   function automatic exp_t model(input logic [31:0] p, input logic [31:0] i,
                                  input logic [1:0] sel);
      exp_t        e;
      logic [31:0] sgn20;
      logic [31:0] bimm;
      logic [31:0] jimm;
      sgn20    = 32'($signed(i) >>> 20);
      e.rd     = (i >> 7) & 32'h1f;
      e.opcode = i & 32'h7f;
      e.funct7 = i >> 25;
      e.funct3 = (i >> 12) & 32'h7;
      case (sel)
         2'b01:   e.imm = (sgn20 & ~32'h1f) | ((i >> 7) & 32'h1f);
         2'b10:   e.imm = i & 32'hfffff000;
         default: e.imm = sgn20;
      endcase
      bimm = (32'($signed(i) >>> 19) & 32'hfffff000) | ((i << 4) & 32'h800)
           | ((i >> 20) & 32'h7e0) | ((i >> 7) & 32'h1e);
      jimm = (32'($signed(i) >>> 11) & 32'hfff00000) | (i & 32'h000ff000)
           | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7fe);
      e.bt  = p + bimm;
      e.jt  = p + jimm;
      e.rs1 = ref_rf[(i >> 15) & 32'h1f];
      e.rs2 = ref_rf[(i >> 20) & 32'h1f];
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check_eq({tag, ".rd"},     32'(rd),     e.rd);
      check_eq({tag, ".opcode"}, 32'(opcode), e.opcode);
      check_eq({tag, ".funct7"}, 32'(funct7), e.funct7);
      check_eq({tag, ".funct3"}, 32'(funct3), e.funct3);
      check_eq({tag, ".imm"},    extend_imm,  e.imm);
      check_eq({tag, ".btgt"},   branch_target, e.bt);
      check_eq({tag, ".jtgt"},   jal_target,  e.jt);
      check_eq({tag, ".rs1"},    rs1_data,    e.rs1);
      check_eq({tag, ".rs2"},    rs2_data,    e.rs2);
   endtask

   // Drive a vector between edges; known constants from the decoding of real instructions
   // override the model so both are cross-checked against the DUT.
   task automatic drive(input string tag, input logic [31:0] p, input logic [31:0] i,
                        input logic [1:0] sel, input exp_t ovr, input logic [8:0] use_ovr);
      exp_t e;
      @(negedge clock);
      pc          = p;
      instruction = i;
      extend_sel  = sel;
      e = model(p, i, sel);
      if (use_ovr[0]) e.rd     = ovr.rd;
      if (use_ovr[1]) e.opcode = ovr.opcode;
      if (use_ovr[3]) e.funct3 = ovr.funct3;
      if (use_ovr[4]) e.imm    = ovr.imm;
      if (use_ovr[5]) e.bt     = ovr.bt;
      if (use_ovr[6]) e.jt     = ovr.jt;
      if (use_ovr[7]) e.rs1    = ovr.rs1;
      sb_q.push_back(e);
      #1;
      compare(tag);
   endtask

   task automatic rf_write(input logic [4:0] r, input logic [31:0] d);
      @(negedge clock);
      write      = 1'b1;
      write_reg  = r;
      write_data = d;
      @(posedge clock);
      if (!reset && r != 5'd0) ref_rf[r] = d;
      #1;
      write = 1'b0;
   endtask

   exp_t o;

   initial begin
      reset       = 1'b1;
      pc          = '0;
      instruction = '0;
      extend_sel  = 2'b00;
      write       = 1'b0;
      write_reg   = '0;
      write_data  = '0;
      scan        = 1'b0;
      o           = '{default: '0};
      for (int k = 0; k < 32; k++) ref_rf[k] = '0;

      // Outputs during reset with all-zero inputs.
      #2;
      sb_q.push_back(model(32'h0, 32'h0, 2'b00));
      compare("reset");
      #10;
      reset = 1'b0;

      o.rd = 2; o.opcode = 32'h13; o.funct3 = 0; o.imm = 32'hffffffe0;
      drive("addi_sp", 32'h4, 32'hfe010113, 2'b00, o, 9'b000011011);
      o.opcode = 32'h23; o.funct3 = 2; o.imm = 32'h0000001c;
      drive("sw_ra", 32'h8, 32'h00112e23, 2'b01, o, 9'b000011010);
      o.imm = 32'hffffffec;
      drive("sw_a5", 32'hc, 32'hfef42623, 2'b01, o, 9'b000010000);
      o.rd = 8; o.imm = 32'h20;
      drive("addi_s0", 32'h10, 32'h02010413, 2'b00, o, 9'b000010001);
      o.rd = 15; o.imm = 32'h4;
      drive("addi_a5", 32'h14, 32'h00400793, 2'b00, o, 9'b000010001);
      o.bt = 32'h000000f8;
      drive("beq", 32'h100, 32'hfe000ce3, 2'b00, o, 9'b000100000);
      o.jt = 32'h00000900; o.rd = 1;
      drive("jal", 32'h100, 32'h001000ef, 2'b00, o, 9'b001000001);
      o.imm = 32'h12345000;
      drive("lui", 32'h0, 32'h123452b7, 2'b10, o, 9'b000010000);
      drive("sel11", 32'h0, 32'h800fff13, 2'b11, o, 9'b000000000);
      drive("bwrap", 32'hfffffffc, 32'h00000463, 2'b00, o, 9'b000000000);

      // No bypass: old value before the edge, new value after it.
      @(negedge clock);
      instruction = 32'h00028013;
      write = 1'b1; write_reg = 5'd5; write_data = 32'hdeadbeef;
      #1;
      check_eq("x5_pre_edge", rs1_data, 32'h0);
      @(posedge clock);
      ref_rf[5] = 32'hdeadbeef;
      #1;
      write = 1'b0;
      check_eq("x5_post_edge", rs1_data, 32'hdeadbeef);
      o.rs1 = 32'hdeadbeef;
      drive("rd_x5", 32'h20, 32'h00028013, 2'b00, o, 9'b010000000);

      rf_write(5'd0, 32'h1234);
      drive("x0_read", 32'h24, 32'h00000013, 2'b00, o, 9'b000000000);
      check_eq("x0_rs1", rs1_data, 32'h0);

      // Scan has no functional effect.
      scan = 1'b1;
      o.imm = 32'h12345000;
      drive("scan_on", 32'h0, 32'h123452b7, 2'b10, o, 9'b000010000);
      scan = 1'b0;

      // Random writes and decodes against the model.
      for (int k = 0; k < 12; k++) begin
         rf_write(5'($urandom_range(0, 31)), $urandom);
      end
      for (int k = 0; k < 16; k++) begin
         drive("rand", $urandom, $urandom, 2'($urandom_range(0, 3)), o, 9'b000000000);
      end

      // Asynchronous reset mid-cycle clears the file without a clock edge.
      @(negedge clock);
      instruction = 32'h00028013;
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_rst", rs1_data, 32'h0);
      for (int k = 0; k < 32; k++) ref_rf[k] = '0;

      // A write coinciding with reset is lost.
      rf_write(5'd5, 32'hcafef00d);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_eq("wr_in_rst", rs1_data, 32'h0);
      drive("post_rst", 32'h40, 32'h00528033, 2'b00, o, 9'b000000000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_unit.md
# decode_unit

Instruction-decode stage of the RV32I base core. It slices the fetched instruction into its fields and produces the sign-extended immediate selected by the control unit. It also computes the branch and JAL targets and holds the 32-entry integer register file, written back from the writeback stage. It sits between the fetch and execute stages and feeds the control unit (opcode/funct fields) and the ALU (operands and immediate).

## Interface
- CORE, 0, core index; printed in scan output only
- DATA_WIDTH, 32, register and operand width
- ADDRESS_BITS, 32, PC and target width
- clock  in  1  single clock; all register-file writes on its rising edge
- reset  in  1  asynchronous, active-high; clears every register-file entry to 0
- PC  in  ADDRESS_BITS  address of the instruction being decoded
- instruction  in  32  instruction word
- extend_sel  in  2  immediate format: 00 I, 01 S, 10 U, 11 I
- write  in  1  register-file write enable
- write_reg  in  5  destination register index
- write_data  in  DATA_WIDTH  data to write
- rs1_data  out  DATA_WIDTH  contents of register instruction[19:15]
- rs2_data  out  DATA_WIDTH  contents of register instruction[24:20]
- rd  out  5  instruction[11:7]
- opcode  out  7  instruction[6:0]
- funct7  out  7  instruction[31:25]
- funct3  out  3  instruction[14:12]
- extend_imm  out  DATA_WIDTH  selected immediate
- branch_target  out  ADDRESS_BITS  PC + B-immediate
- JAL_target  out  ADDRESS_BITS  PC + J-immediate
- scan  in  1  debug print enable; no functional effect

## Operation
- Field outputs (rd, opcode, funct7, funct3) are pure combinational slices of instruction.
- extend_imm:
  - I format (extend_sel 00 or 11): sign-extend instruction[31:20].
  - S format (extend_sel 01): sign-extend {instruction[31:25], instruction[11:7]}.
  - U format (extend_sel 10): {instruction[31:12], 12'b0}.
- B-immediate: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- J-immediate: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- branch_target = PC + B-immediate and JAL_target = PC + J-immediate. Both are computed unconditionally, truncated modulo 2^ADDRESS_BITS, and wrap with no overflow flag.
- Register file: 32 × DATA_WIDTH entries, with two asynchronous read ports and one synchronous write port.
- Register x0 always reads 0. Writes with write_reg = 0 are discarded.
- Write: on the rising edge of clock, when write = 1 and write_reg ≠ 0, the entry at write_reg ← write_data.
- There is no write-to-read bypass. A read of the register being written returns the old value until that edge, then the new value.
- Reset asserted clears all entries immediately, regardless of clock. This includes reset asserted mid-operation. A write coinciding with reset is lost.
- scan = 1: at each rising edge, display CORE, PC, instruction, rd, rs1/rs2 indices and data, extend_imm and any write in progress.

## Timing
- All decode outputs, immediates and targets are combinational from PC/instruction/extend_sel, so they are valid in the same cycle. Latency is 0.
- rs1_data/rs2_data follow register contents combinationally and reflect a write one edge after it is presented.
- Reset values:
  - Register file all 0, so rs1_data/rs2_data = 0 while reset is high and after reset until written.
  - All other outputs follow their inputs; they are 0 for instruction = 0, PC = 0.
- No handshakes and no state machine; the only state is the register file.

## Test plan
- addi sp,sp,-32: PC=0x4, instruction=0xfe010113, extend_sel=00 -> rd=2, opcode=0x13, funct3=0, extend_imm=0xffffffe0.
- sw ra,28(sp): 0x00112e23, extend_sel=01 -> opcode=0x23, funct3=2, extend_imm=0x0000001c. sw a5,-20(s0): 0xfef42623, extend_sel=01 -> extend_imm=0xffffffec.
- addi s0,sp,32: 0x02010413, extend_sel=00 -> rd=8, extend_imm=0x20. addi a5,zero,4: 0x00400793 -> rd=15, extend_imm=0x4.
- Register file:
  - Write x5 = 0xdeadbeef, then present an instruction with rs1=5 -> rs1_data = 0xdeadbeef after the edge.
  - Write x0 = 0x1234 -> reads 0.
  - Assert reset asynchronously -> rs1_data = 0 without a clock edge.
- beq x0,x0,-8: PC=0x100, 0xfe000ce3 -> branch_target = 0x000000f8. jal x1,+0x800: PC=0x100, 0x001000ef -> JAL_target = 0x00000900, rd=1.
- U format: 0x123452b7 with extend_sel=10 -> extend_imm = 0x12345000. Toggling scan changes no output.
